// File: rtl/delay_meter.sv
// Measures drv-rise to fb-rise loop delay in clk cycles and publishes the average of 2^AVG_SHIFT samples.
// Latency: valid pulses the cycle after the final fb edge; no backpressure. Optional min/max tracking: DELAY_METER_MINMAX_EN.
module delay_meter #(
    parameter int CNT_MAX   = 255,
    parameter int AVG_SHIFT = 2,
    localparam int W        = $clog2(CNT_MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         drv,
    input  logic         fb,
    output logic [W-1:0] delay,
    output logic         valid,
    output logic         timeout
`ifdef DELAY_METER_MINMAX_EN
    ,
    output logic [W-1:0] dly_min,
    output logic [W-1:0] dly_max
`endif
);

    localparam int AW = W + AVG_SHIFT;
    localparam int NW = AVG_SHIFT + 1;
    localparam logic [NW-1:0] NLAST = NW'((1 << AVG_SHIFT) - 1);
    localparam logic [W-1:0]  CMAX  = W'(CNT_MAX);

    typedef enum logic {IDLE, MEAS} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  cnt, cnt_nxt, sample;
    logic [AW-1:0] acc, sum;
    logic [NW-1:0] nsamp;
    logic          drv_d, fb_d, rise_drv, rise_fb, rec, tmo_set;

    assign rise_drv = drv & ~drv_d;
    assign rise_fb  = fb & ~fb_d;
    assign sum      = acc + AW'(sample);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rec       = 1'b0;
        sample    = '0;
        tmo_set   = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise_drv && rise_fb) begin
                        rec = 1'b1;
                    end else if (rise_drv) begin
                        state_nxt = MEAS;
                        cnt_nxt   = W'(1);
                    end
                end
                MEAS: begin
                    if (rise_fb) begin
                        rec    = 1'b1;
                        sample = cnt;
                        if (rise_drv) begin
                            cnt_nxt = W'(1);
                        end else begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end
                    end else if (rise_drv) begin
                        // A new drive edge supersedes the pending attempt.
                        cnt_nxt = W'(1);
                    end else if (cnt == CMAX) begin
                        tmo_set   = 1'b1;
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            nsamp   <= '0;
            drv_d   <= 1'b0;
            fb_d    <= 1'b0;
            delay   <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
`ifdef DELAY_METER_MINMAX_EN
            dly_min <= CMAX;
            dly_max <= '0;
`endif
        end else begin
            drv_d <= drv;
            fb_d  <= fb;
            state <= state_nxt;
            cnt   <= cnt_nxt;
            valid <= 1'b0;
            if (!en) begin
                acc   <= '0;
                nsamp <= '0;
`ifdef DELAY_METER_MINMAX_EN
                dly_min <= CMAX;
                dly_max <= '0;
`endif
            end else begin
                if (tmo_set) begin
                    timeout <= 1'b1;
                end
                if (rec) begin
                    if (nsamp == NLAST) begin
                        delay   <= W'(sum >> AVG_SHIFT);
                        valid   <= 1'b1;
                        timeout <= 1'b0;
                        acc     <= '0;
                        nsamp   <= '0;
                    end else begin
                        acc   <= sum;
                        nsamp <= nsamp + NW'(1);
                    end
`ifdef DELAY_METER_MINMAX_EN
                    if (sample < dly_min) dly_min <= sample;
                    if (sample > dly_max) dly_max <= sample;
`endif
                end
            end
        end
    end

endmodule
